// File: rtl/vliw_pkg.sv
// Shared types and sizing for the VLIW issue-stage scoreboard.
// Register indices are 6 bits; write tags are {enable, index}.
package vliw_pkg;

    localparam int NREG  = 64;
    localparam int CNTW  = 3;
    localparam int NSLOT = 4;

    typedef logic [5:0] reg_idx_t;

    typedef struct packed {
        logic     en;
        reg_idx_t idx;
    } wb_tag_t;

    typedef logic [CNTW-1:0] lat_t;

    // A zero latency marks a load whose completion arrives on a writeback port.
    localparam lat_t LAT_VAR = '0;

endpackage

// File: rtl/vliw_scoreboard_if.sv
// Decode-to-scoreboard bundle: per-slot sources, destinations and latencies,
// the four writeback tags, and the issue handshake.
interface vliw_scoreboard_if;
    import vliw_pkg::*;

    logic     issue_valid;
    logic     issue_ready;
    reg_idx_t rs11, rs12, rs21, rs22, rs31, rs32, rs41, rs42;
    wb_tag_t  rd1, rd2, rd3, rd4;
    lat_t     lat1, lat2, lat3, lat4;
    wb_tag_t  wb_rd1, wb_rd2, wb_rd3, wb_rd4;
    logic [NREG-1:0] busy_vec;

    modport master (
        output issue_valid,
        output rs11, rs12, rs21, rs22, rs31, rs32, rs41, rs42,
        output rd1, rd2, rd3, rd4,
        output lat1, lat2, lat3, lat4,
        output wb_rd1, wb_rd2, wb_rd3, wb_rd4,
        input  issue_ready,
        input  busy_vec
    );

    modport slave (
        input  issue_valid,
        input  rs11, rs12, rs21, rs22, rs31, rs32, rs41, rs42,
        input  rd1, rd2, rd3, rd4,
        input  lat1, lat2, lat3, lat4,
        input  wb_rd1, wb_rd2, wb_rd3, wb_rd4,
        output issue_ready,
        output busy_vec
    );

endinterface

// File: rtl/sb_entry.sv
// Per-register in-flight tracker: a countdown for fixed-latency producers
// and a pending flag for loads waiting on a writeback port.
module sb_entry #(
    parameter int CNTW = vliw_pkg::CNTW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            set_fix,
    input  logic            set_var,
    input  logic [CNTW-1:0] set_lat,
    input  logic            wb_hit,
    output logic            busy,
    output logic [CNTW-1:0] cnt,
    output logic            mem_pend
);

    logic [CNTW-1:0] cnt_reg;
    logic            mem_pend_reg;

    // A new issue to this register overrides any same-cycle decrement or writeback.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg      <= '0;
            mem_pend_reg <= 1'b0;
        end else if (set_fix) begin
            cnt_reg      <= set_lat;
            mem_pend_reg <= 1'b0;
        end else if (set_var) begin
            cnt_reg      <= '0;
            mem_pend_reg <= 1'b1;
        end else begin
            if (cnt_reg != '0) begin
                cnt_reg <= cnt_reg - CNTW'(1);
            end
            if (wb_hit) begin
                mem_pend_reg <= 1'b0;
            end
        end
    end

    assign cnt      = cnt_reg;
    assign mem_pend = mem_pend_reg;
    assign busy     = (cnt_reg != '0) | mem_pend_reg;

endmodule

// File: rtl/vliw_scoreboard.sv
// Issue-stage hazard controller: stalls the whole bundle while any source
// or enabled destination register still has a write in flight.
module vliw_scoreboard #(
    parameter int NREG = vliw_pkg::NREG,
    parameter int CNTW = vliw_pkg::CNTW
) (
    input  logic             clk,
    input  logic             rst,
    vliw_scoreboard_if.slave sb
);
    import vliw_pkg::*;

    reg_idx_t        rs_a [NSLOT];
    reg_idx_t        rs_b [NSLOT];
    wb_tag_t         rd   [NSLOT];
    logic [CNTW-1:0] lat  [NSLOT];
    wb_tag_t         wb   [NSLOT];

    assign rs_a = '{sb.rs11, sb.rs21, sb.rs31, sb.rs41};
    assign rs_b = '{sb.rs12, sb.rs22, sb.rs32, sb.rs42};
    assign rd   = '{sb.rd1, sb.rd2, sb.rd3, sb.rd4};
    assign lat  = '{sb.lat1, sb.lat2, sb.lat3, sb.lat4};
    assign wb   = '{sb.wb_rd1, sb.wb_rd2, sb.wb_rd3, sb.wb_rd4};

    logic [NREG-1:0]           busy;
    logic [NREG-1:0][CNTW-1:0] cnt;
    logic [NREG-1:0]           mem_pend;
    logic                      hazard;
    logic                      fire;

    // Register 0 is hardwired and can never hold a pending write.
    assign busy[0]     = 1'b0;
    assign cnt[0]      = '0;
    assign mem_pend[0] = 1'b0;

    // Only registered state feeds the hazard, so wb_rd* never reaches issue_ready.
    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < NSLOT; k++) begin
            hazard = hazard | busy[rs_a[k]] | busy[rs_b[k]]
                   | (rd[k].en & busy[rd[k].idx]);
        end
    end

    assign sb.issue_ready = ~hazard;
    assign fire           = sb.issue_valid & ~hazard;

    for (genvar gi = 1; gi < NREG; gi++) begin : g_entry
        logic            hit;
        logic            wb_hit;
        logic [CNTW-1:0] set_lat;
        logic            set_fix;
        logic            set_var;

        // Later slots override earlier ones if a bundle names the same rd twice.
        always_comb begin
            hit     = 1'b0;
            set_lat = '0;
            for (int k = 0; k < NSLOT; k++) begin
                if (rd[k].en && (rd[k].idx == reg_idx_t'(gi))) begin
                    hit     = 1'b1;
                    set_lat = lat[k];
                end
            end
        end

        always_comb begin
            wb_hit = 1'b0;
            for (int j = 0; j < NSLOT; j++) begin
                if (wb[j].en && (wb[j].idx == reg_idx_t'(gi))) begin
                    wb_hit = 1'b1;
                end
            end
        end

        assign set_fix = fire & hit & (set_lat != LAT_VAR);
        assign set_var = fire & hit & (set_lat == LAT_VAR);

        sb_entry #(.CNTW(CNTW)) u_entry (
            .clk      (clk),
            .rst      (rst),
            .set_fix  (set_fix),
            .set_var  (set_var),
            .set_lat  (set_lat),
            .wb_hit   (wb_hit),
            .busy     (busy[gi]),
            .cnt      (cnt[gi]),
            .mem_pend (mem_pend[gi])
        );
    end

    // Debug view rebuilt from the raw per-register state.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_busy_vec
        assign sb.busy_vec[gi] = (cnt[gi] != '0) | mem_pend[gi];
    end

endmodule

// File: tb/tb_vliw_scoreboard.sv
// Directed scenarios plus randomized bundles, checked against a timestamp
// model of register availability.
module tb_vliw_scoreboard;
    import vliw_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vliw_scoreboard_if sbif ();

    vliw_scoreboard dut (
        .clk (clk),
        .rst (rst),
        .sb  (sbif)
    );

    logic     valid;
    reg_idx_t rs_a [4];
    reg_idx_t rs_b [4];
    wb_tag_t  rd   [4];
    lat_t     lat  [4];
    wb_tag_t  wb   [4];

    assign sbif.issue_valid = valid;
    assign sbif.rs11 = rs_a[0];
    assign sbif.rs12 = rs_b[0];
    assign sbif.rs21 = rs_a[1];
    assign sbif.rs22 = rs_b[1];
    assign sbif.rs31 = rs_a[2];
    assign sbif.rs32 = rs_b[2];
    assign sbif.rs41 = rs_a[3];
    assign sbif.rs42 = rs_b[3];
    assign sbif.rd1  = rd[0];
    assign sbif.rd2  = rd[1];
    assign sbif.rd3  = rd[2];
    assign sbif.rd4  = rd[3];
    assign sbif.lat1 = lat[0];
    assign sbif.lat2 = lat[1];
    assign sbif.lat3 = lat[2];
    assign sbif.lat4 = lat[3];
    assign sbif.wb_rd1 = wb[0];
    assign sbif.wb_rd2 = wb[1];
    assign sbif.wb_rd3 = wb[2];
    assign sbif.wb_rd4 = wb[3];

    int n_checks = 0;
    int n_errors = 0;

    // Model: a fixed-latency write frees its register at a known edge number;
    // a load keeps it pending until a writeback edge.
    int edge_n;
    int free_edge [64];
    bit pend      [64];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    function automatic bit m_busy(input int r);
        return (r != 0) && ((edge_n < free_edge[r]) || pend[r]);
    endfunction

    function automatic logic [63:0] m_busy_vec();
        logic [63:0] v;
        for (int r = 0; r < 64; r++) v[r] = m_busy(r);
        return v;
    endfunction

    function automatic bit m_ready();
        bit haz;
        haz = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (m_busy(int'(rs_a[k])) || m_busy(int'(rs_b[k]))) haz = 1'b1;
            if (rd[k].en && m_busy(int'(rd[k].idx))) haz = 1'b1;
        end
        return !haz;
    endfunction

    task automatic m_clear();
        for (int r = 0; r < 64; r++) begin
            free_edge[r] = 0;
            pend[r]      = 1'b0;
        end
    endtask

    task automatic m_edge(input bit fire);
        edge_n++;
        for (int j = 0; j < 4; j++) begin
            if (wb[j].en) pend[wb[j].idx] = 1'b0;
        end
        if (fire) begin
            for (int k = 0; k < 4; k++) begin
                if (rd[k].en && rd[k].idx != 0) begin
                    if (lat[k] != 0) begin
                        free_edge[rd[k].idx] = edge_n + int'(lat[k]);
                        pend[rd[k].idx]      = 1'b0;
                    end else begin
                        free_edge[rd[k].idx] = 0;
                        pend[rd[k].idx]      = 1'b1;
                    end
                end
            end
        end
    endtask

    function automatic wb_tag_t tag_of(input int r);
        return {1'b1, reg_idx_t'(r)};
    endfunction

    task automatic idle_inputs();
        valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rs_a[k] = '0;
            rs_b[k] = '0;
            rd[k]   = '0;
            lat[k]  = '0;
            wb[k]   = '0;
        end
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic tick(input string tag, output bit fired, output bit got_ready);
        bit exp_ready;
        @(negedge clk);
        exp_ready = m_ready();
        got_ready = sbif.issue_ready;
        check({tag, ".ready"}, got_ready, exp_ready);
        check({tag, ".busy_vec"}, sbif.busy_vec, m_busy_vec());
        @(posedge clk);
        fired = valid && exp_ready;
        m_edge(fired);
        #1;
    endtask

    task automatic step(input string tag);
        bit f, g;
        tick(tag, f, g);
    endtask

    task automatic issue_until(input string tag, input int bound, output int stalls);
        bit f, g;
        f = 1'b0;
        stalls = 0;
        for (int i = 0; i < bound && !f; i++) begin
            tick(tag, f, g);
            if (!g) stalls++;
        end
        check({tag, ".issued"}, f, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time bound");
        $fatal(1);
    end

    int pool [12] = '{0, 1, 2, 3, 5, 7, 31, 32, 33, 40, 62, 63};

    initial begin
        int stalls;
        edge_n = 0;
        rst = 1'b1;
        idle_inputs();
        m_clear();
        repeat (2) @(posedge clk);
        #1;
        check("init.ready", sbif.issue_ready, 1);
        check("init.busy_vec", sbif.busy_vec, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        m_edge(1'b0);
        #1;

        // RAW on a fixed-latency producer
        idle_inputs(); valid = 1'b1; rd[0] = tag_of(10); lat[0] = 3;
        step("raw.prod");
        idle_inputs(); valid = 1'b1; rs_a[0] = 10;
        issue_until("raw.cons", 12, stalls);
        check("raw.stalls", stalls, 3);

        // Load: consumer waits for the writeback, then one more cycle
        idle_inputs(); valid = 1'b1; rd[2] = tag_of(40); lat[2] = 0;
        step("load.prod");
        idle_inputs(); valid = 1'b1; rs_b[1] = 40;
        repeat (5) step("load.wait");
        wb[2] = tag_of(40);
        step("load.wb");
        wb[2] = '0;
        issue_until("load.cons", 4, stalls);
        check("load.after_wb", stalls, 0);

        // WAW against an outstanding load
        idle_inputs(); valid = 1'b1; rd[0] = tag_of(7); lat[0] = 0;
        step("waw.load");
        idle_inputs(); valid = 1'b1; rd[1] = tag_of(7); lat[1] = 1;
        repeat (3) step("waw.wait");
        wb[3] = tag_of(7);
        step("waw.wb");
        wb[3] = '0;
        issue_until("waw.cons", 4, stalls);
        check("waw.after_wb", stalls, 0);
        idle_inputs();
        check("waw.busy7_set", sbif.busy_vec[7], 1);
        repeat (2) step("waw.drain");

        // Register 0 never stalls; a stray writeback changes nothing
        idle_inputs(); valid = 1'b1; rd[0] = tag_of(0); lat[0] = 5;
        step("r0.prod");
        idle_inputs(); valid = 1'b1; rs_a[0] = 0; rd[1] = tag_of(0);
        issue_until("r0.cons", 3, stalls);
        check("r0.stalls", stalls, 0);
        idle_inputs(); wb[0] = tag_of(20);
        step("spur.wb");
        idle_inputs();
        step("spur.after");

        // Four slots at once: three lat-7 writes and one load
        idle_inputs(); valid = 1'b1;
        rd[0] = tag_of(1);  lat[0] = 7;
        rd[1] = tag_of(33); lat[1] = 7;
        rd[2] = tag_of(34); lat[2] = 7;
        rd[3] = tag_of(2);  lat[3] = 0;
        step("quad.issue");
        idle_inputs();
        check("quad.busy_set", sbif.busy_vec & 64'h0000_0006_0000_0006, 64'h0000_0006_0000_0006);
        repeat (9) step("quad.drain");
        wb[1] = tag_of(2);
        step("quad.wb");
        idle_inputs();
        step("quad.idle");

        // Asynchronous reset while r5 is still counting down
        idle_inputs(); valid = 1'b1; rd[0] = tag_of(5); lat[0] = 4;
        step("rst.prod");
        idle_inputs();
        step("rst.count");
        valid = 1'b1; rs_a[0] = 5;
        rst = 1'b1;
        #1;
        m_clear();
        check("rst_mid.busy_vec", sbif.busy_vec, 0);
        check("rst_mid.ready", sbif.issue_ready, 1);
        @(posedge clk);
        @(negedge clk);
        check("rst_hold.ready", sbif.issue_ready, 1);
        rst = 1'b0;
        @(posedge clk);
        m_edge(valid && m_ready());
        #1;
        issue_until("rst.cons", 2, stalls);
        check("rst.stalls", stalls, 0);

        // Randomized bundles and writebacks over a small register pool
        for (int c = 0; c < 3000; c++) begin
            idle_inputs();
            valid = ($urandom_range(0, 4) != 0);
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 9) < 4) rs_a[k] = reg_idx_t'(pool[$urandom_range(0, 11)]);
                if ($urandom_range(0, 9) < 4) rs_b[k] = reg_idx_t'(pool[$urandom_range(0, 11)]);
                if ($urandom_range(0, 9) < 3) rd[k] = tag_of(pool[$urandom_range(0, 11)]);
                lat[k] = lat_t'($urandom_range(0, 7));
                if ($urandom_range(0, 3) == 0) wb[k] = tag_of(pool[$urandom_range(0, 11)]);
            end
            step("rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
